// File: rtl/rf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rf_pkg                                                  |
// | Desc   : Shared constants and clear-FSM state type for the       |
// |          multi-read-port register file.                          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package rf_pkg;
  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_ZERO_ADDR = 0;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_IDLE = 1'b1
  } rf_state_e;
endpackage
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rf_clear_seq                                            |
// | Desc   : Clear sequencer. Sweeps a zero write across every       |
// |          register after reset or on a clear request.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  // State and sweep pointer; reset always restarts the sweep from r0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RF_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: walk the pointer to the last register, then idle until a clear request.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RF_INIT: begin
        if (r_ptr == c_LAST) begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_INIT;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = RF_INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign init_busy = (r_state == RF_INIT);
  assign clr_we    = (r_state == RF_INIT);
  assign clr_addr  = r_ptr;
endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : reg_file_mp                                             |
// | Desc   : Register file with NUM_RD combinational read ports,     |
// |          one write port, optional write-to-read bypass, r0 tied  |
// |          to zero and a built-in clear sweep.                     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     clr_req,
  output logic                     init_busy
);
  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ext_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .init_busy (init_busy),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  // External writes only count while idle and never touch r0.
  assign w_ext_we = we && !init_busy && (waddr != c_ZERO);

  // The sweep owns the write port outright; external writes during it are lost.
  assign w_we    = w_clr_we ? 1'b1       : w_ext_we;
  assign w_waddr = w_clr_we ? w_clr_addr : waddr;
  assign w_wdata = w_clr_we ? '0         : wdata;

  // Single write port into the storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read priority: reset/sweep/disabled, then r0, then bypass, then storage.
    always_comb begin
      w_rd = '0;
      if (!rst || init_busy || !rd_en[k]) begin
        w_rd = '0;
      end else if (w_ra == c_ZERO) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && we && (waddr == w_ra)) begin
        w_rd = wdata;
      end else begin
        w_rd = r_mem[w_ra];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_rd;
  end
endmodule
`default_nettype wire
